// File: rtl/blk_sram_writer_pkg.sv
// blk_sram_writer_pkg: shared block geometry, FSM states and width helper for the SRAM block writer.
package blk_sram_writer_pkg;
  localparam int BLK_DIM = 8;
  localparam int WORDS_PER_BLK = 32;
  localparam int PIX_W = 8;
  typedef enum logic [2:0] {S_IDLE, S_RD_EVEN, S_RD_ODD, S_LATCH, S_WRITE} state_e;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/blk_sram_writer_pos.sv
// blk_pos_counter: raster block position (bx, by) that advances once per completed block and wraps per frame.
module blk_pos_counter #(
  parameter int NBX = 40,
  parameter int NBY = 30,
  parameter int BXW = 6,
  parameter int BYW = 5
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           en,
  output logic [BXW-1:0] bx,
  output logic [BYW-1:0] by,
  output logic           last
);
  logic [BXW-1:0] bx_q, bx_d;
  logic [BYW-1:0] by_q, by_d;
  logic bx_end, by_end;
  always_comb begin
    bx_end = bx_q == BXW'(NBX - 1);
    by_end = by_q == BYW'(NBY - 1);
    bx_d = !en ? bx_q : bx_end ? '0 : bx_q + 1'b1;
    by_d = !(en && bx_end) ? by_q : by_end ? '0 : by_q + 1'b1;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      bx_q <= '0;
      by_q <= '0;
    end else begin
      bx_q <= bx_d;
      by_q <= by_d;
    end
  assign bx = bx_q;
  assign by = by_q;
  assign last = bx_end && by_end;
endmodule

// File: rtl/blk_sram_writer.sv
// blk_sram_writer: reads an 8x8 pixel block, packs pixel pairs and writes them at the block's raster address.
// Optional BLK_WR_CHECKSUM_EN adds a 16-bit per-block pixel checksum output.
module blk_sram_writer
  import blk_sram_writer_pkg::*;
#(
  parameter int AW    = 18,
  parameter int DW    = 16,
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  output logic [2:0]       rd_row,
  output logic [2:0]       rd_col,
  input  logic [PIX_W-1:0] pix_in,
  output logic [AW-1:0]    sram_addr,
  output logic [DW-1:0]    sram_wdata,
  output logic             sram_we,
  input  logic             sram_ack,
  output logic             busy,
  output logic             done,
  output logic             frame_done
`ifdef BLK_WR_CHECKSUM_EN
  ,
  output logic [15:0]      checksum
`endif
);
  localparam int NBX = IMG_W / BLK_DIM;
  localparam int NBY = IMG_H / BLK_DIM;
  localparam int BXW = clog2_min1(NBX);
  localparam int BYW = clog2_min1(NBY);
  localparam int PITCH = IMG_W / 2;

  state_e state_q, state_d;
  logic [4:0] w_q, w_d, w_nxt;
  logic [AW-1:0] base_q, base_d, addr_q, addr_d, addr_calc;
  logic [PIX_W-1:0] even_q, even_d;
  logic [2:0] rd_row_q, rd_row_d, rd_col_q, rd_col_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic we_q, we_d, busy_q, busy_d, done_q, done_d, frame_q, frame_d, adv, last;
  logic [BXW-1:0] bx;
  logic [BYW-1:0] by;
`ifdef BLK_WR_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;
`endif

  blk_pos_counter #(.NBX(NBX), .NBY(NBY), .BXW(BXW), .BYW(BYW)) u_pos (
    .clock(clock), .reset_n(reset_n), .en(adv), .bx(bx), .by(by), .last(last)
  );

  // by*8+row and bx*4+w[1:0] are plain bit concatenations
  assign addr_calc = base_q + AW'({by, w_q[4:2]}) * AW'(PITCH) + AW'({bx, w_q[1:0]});
  assign w_nxt = w_q + 5'd1;

  always_comb begin
    state_d = state_q;
    w_d = w_q;
    base_d = base_q;
    even_d = even_q;
    rd_row_d = rd_row_q;
    rd_col_d = rd_col_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = we_q;
    done_d = 1'b0;
    frame_d = 1'b0;
    adv = 1'b0;
`ifdef BLK_WR_CHECKSUM_EN
    csum_d = csum_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RD_EVEN;
        base_d = base_addr;
        w_d = '0;
        rd_row_d = '0;
        rd_col_d = '0;
`ifdef BLK_WR_CHECKSUM_EN
        csum_d = '0;
`endif
      end
      S_RD_EVEN: begin
        state_d = S_RD_ODD;
        rd_col_d = {w_q[1:0], 1'b1};
      end
      S_RD_ODD: begin
        state_d = S_LATCH;
        even_d = pix_in;
`ifdef BLK_WR_CHECKSUM_EN
        csum_d = csum_q + 16'(pix_in);
`endif
      end
      S_LATCH: begin
        state_d = S_WRITE;
        wdata_d = {pix_in, even_q};
        addr_d = addr_calc;
        we_d = 1'b1;
`ifdef BLK_WR_CHECKSUM_EN
        csum_d = csum_q + 16'(pix_in);
`endif
      end
      S_WRITE: if (sram_ack) begin
        we_d = 1'b0;
        if (w_q == 5'(WORDS_PER_BLK - 1)) begin
          state_d = S_IDLE;
          done_d = 1'b1;
          adv = 1'b1;
          frame_d = last;
        end else begin
          state_d = S_RD_EVEN;
          w_d = w_nxt;
          rd_row_d = w_nxt[4:2];
          rd_col_d = {w_nxt[1:0], 1'b0};
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      w_q <= '0;
      base_q <= '0;
      even_q <= '0;
      rd_row_q <= '0;
      rd_col_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      frame_q <= 1'b0;
`ifdef BLK_WR_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      base_q <= base_d;
      even_q <= even_d;
      rd_row_q <= rd_row_d;
      rd_col_q <= rd_col_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      busy_q <= busy_d;
      done_q <= done_d;
      frame_q <= frame_d;
`ifdef BLK_WR_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end

  assign rd_row = rd_row_q;
  assign rd_col = rd_col_q;
  assign sram_addr = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_we = we_q;
  assign busy = busy_q;
  assign done = done_q;
  assign frame_done = frame_q;
`ifdef BLK_WR_CHECKSUM_EN
  assign checksum = csum_q;
`endif
endmodule

// File: tb/tb_blk_sram_writer.sv
// tb_blk_sram_writer: directed bench for blk_sram_writer on a reduced 48x32 frame (6x4 blocks).
module tb_blk_sram_writer;
  localparam int AW = 18;
  localparam int IMG_W = 48;
  localparam int IMG_H = 32;
  localparam int NBX = IMG_W / 8;
  localparam int NB = NBX * (IMG_H / 8);
  localparam int PITCH = IMG_W / 2;

  logic clock = 0, reset_n = 0, start = 0, sram_ack, sram_we, busy, done, frame_done;
  logic [AW-1:0] base_addr = '0, sram_addr;
  logic [2:0] rd_row, rd_col;
  logic [7:0] pix_in = '0;
  logic [15:0] sram_wdata;
`ifdef BLK_WR_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int errors = 0, checks = 0, cyc = 0, mode = 0, ack_delay = 0, we_cnt = 0, pos = 0;
  logic ack_tie = 1;
  logic [AW-1:0] wa[$];
  logic [15:0] wd[$];
  int first_we, unstable, st, done_at;
  logic fd, busy_mid, busy_done, held = 0, to;
  logic [AW-1:0] h_addr;
  logic [15:0] h_data;

  blk_sram_writer #(.AW(AW), .DW(16), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .rd_row(rd_row), .rd_col(rd_col), .pix_in(pix_in), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_we(sram_we), .sram_ack(sram_ack), .busy(busy),
    .done(done), .frame_done(frame_done)
`ifdef BLK_WR_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] pix(input int r, input int c);
    if (mode == 0) return 8'(8 * r + c);
    if (mode == 1) return 8'hFF;
    return 8'(r * 37 + c * 11 + 5);
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int p, input int base, input int w);
    return AW'(base + ((p / NBX) * 8 + w / 4) * PITCH + (p % NBX) * 4 + w % 4);
  endfunction

  function automatic logic [15:0] exp_data(input int w);
    return {pix(w / 4, 2 * (w % 4) + 1), pix(w / 4, 2 * (w % 4))};
  endfunction

  // pixel buffer: synchronous read, data one cycle after address
  always @(posedge clock) pix_in <= pix(int'(rd_row), int'(rd_col));
  always @(posedge clock) we_cnt <= (sram_we && !sram_ack) ? we_cnt + 1 : 0;
  assign sram_ack = ack_tie | (sram_we && we_cnt >= ack_delay);

  always @(negedge clock) begin
    if (sram_we && first_we < 0) first_we = cyc;
    if (sram_we && held && (sram_addr != h_addr || sram_wdata != h_data)) unstable++;
    if (sram_we && sram_ack) begin
      wa.push_back(sram_addr);
      wd.push_back(sram_wdata);
    end
    held = sram_we && !sram_ack;
    h_addr = sram_addr;
    h_data = sram_wdata;
  end

  task automatic run_block(input logic [AW-1:0] base);
    wa.delete();
    wd.delete();
    first_we = -1;
    unstable = 0;
    done_at = -1;
    fd = 0;
    busy_done = 1;
    @(negedge clock);
    start = 1;
    base_addr = base;
    st = cyc;
    @(negedge clock);
    start = 0;
    busy_mid = busy;
    to = 1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clock);
      #1;
      if (done) begin
        to = 0;
        done_at = cyc;
        fd = frame_done;
        busy_done = busy;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [AW+16+10-1:0] got;
    @(negedge clock);
    got = {sram_addr, sram_wdata, rd_row, rd_col, sram_we, busy, done, frame_done};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    checks++;
    if (sram_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_we: got %b want 0", sram_we);
    end
  endtask

  task automatic test_single_block;
    mode = 0;
    run_block('0);
    checks++;
    if (to) begin errors++; $display("FAIL single_timeout: got no done want done"); end
    checks++;
    if (done_at - st !== 129) begin errors++; $display("FAIL single_done_cycle: got %0d want 129", done_at - st); end
    checks++;
    if (first_we - st !== 4) begin errors++; $display("FAIL single_first_we: got %0d want 4", first_we - st); end
    checks++;
    if (busy_mid !== 1'b1 || busy_done !== 1'b0) begin
      errors++; $display("FAIL single_busy: got mid=%b done=%b want 1/0", busy_mid, busy_done);
    end
    checks++;
    if (fd !== 1'b0) begin errors++; $display("FAIL single_frame_done: got %b want 0", fd); end
    checks++;
    if (wa.size() != 32) begin errors++; $display("FAIL single_count: got %0d want 32", wa.size()); end
    else begin
      checks++;
      if (wa[0] !== 18'd0 || wd[0] !== 16'h0100) begin
        errors++; $display("FAIL single_word0: got %h/%h want 0/0100", wa[0], wd[0]);
      end
      checks++;
      if (wa[5] !== 18'(PITCH + 1) || wd[5] !== 16'h0B0A) begin
        errors++; $display("FAIL single_word5: got %h/%h want %h/0B0A", wa[5], wd[5], PITCH + 1);
      end
      for (int w = 0; w < 32; w++) begin
        checks++;
        if (wa[w] !== exp_addr(pos, 0, w) || wd[w] !== exp_data(w)) begin
          errors++; $display("FAIL single_w%0d: got %h/%h want %h/%h", w, wa[w], wd[w], exp_addr(pos, 0, w), exp_data(w));
        end
      end
    end
    pos = (pos + 1) % NB;
  endtask

  task automatic test_second_block;
    run_block('0);
    checks++;
    if (to || fd !== 1'b0) begin errors++; $display("FAIL second_done: got to=%b fd=%b want 0/0", to, fd); end
    checks++;
    if (wa.size() != 32) begin errors++; $display("FAIL second_count: got %0d want 32", wa.size()); end
    else begin
      checks++;
      if (wa[0] !== 18'd4 || wa[31] !== 18'(7 * PITCH + 7)) begin
        errors++; $display("FAIL second_addr: got %h..%h want 4..%h", wa[0], wa[31], 7 * PITCH + 7);
      end
      for (int w = 0; w < 32; w++) begin
        checks++;
        if (wa[w] !== exp_addr(pos, 0, w) || wd[w] !== exp_data(w)) begin
          errors++; $display("FAIL second_w%0d: got %h/%h want %h/%h", w, wa[w], wd[w], exp_addr(pos, 0, w), exp_data(w));
        end
      end
    end
    pos = (pos + 1) % NB;
  endtask

  task automatic test_ack_delay;
    ack_tie = 0;
    ack_delay = 3;
    run_block(18'h00200);
    checks++;
    if (to || done_at - st !== 225) begin errors++; $display("FAIL delay_cycles: got %0d want 225", done_at - st); end
    checks++;
    if (unstable !== 0) begin errors++; $display("FAIL delay_stable: got %0d changes want 0", unstable); end
    checks++;
    if (wa.size() != 32) begin errors++; $display("FAIL delay_count: got %0d want 32", wa.size()); end
    else for (int w = 0; w < 32; w++) begin
      checks++;
      if (wa[w] !== exp_addr(pos, 'h200, w) || wd[w] !== exp_data(w)) begin
        errors++; $display("FAIL delay_w%0d: got %h/%h want %h/%h", w, wa[w], wd[w], exp_addr(pos, 'h200, w), exp_data(w));
      end
    end
    ack_delay = 0;
    pos = (pos + 1) % NB;
  endtask

  task automatic test_frame;
    int base;
    mode = 2;
    while (pos != 0) begin
      base = pos[0] ? 'h3FFF0 : 'h123;
      run_block(AW'(base));
      checks++;
      if (to || fd !== (pos == NB - 1)) begin
        errors++; $display("FAIL frame_fd_blk%0d: got to=%b fd=%b want fd=%b", pos, to, fd, pos == NB - 1);
      end
      checks++;
      if (wa.size() != 32) begin errors++; $display("FAIL frame_count_blk%0d: got %0d want 32", pos, wa.size()); end
      else for (int w = 0; w < 32; w++) begin
        checks++;
        if (wa[w] !== exp_addr(pos, base, w) || wd[w] !== exp_data(w)) begin
          errors++; $display("FAIL frame_blk%0d_w%0d: got %h/%h want %h/%h", pos, w, wa[w], wd[w], exp_addr(pos, base, w), exp_data(w));
        end
      end
      pos = (pos + 1) % NB;
    end
    run_block(18'h00040);
    checks++;
    if (to || fd !== 1'b0 || wa.size() != 32 || wa[0] !== 18'h00040) begin
      errors++; $display("FAIL frame_wrap: got to=%b fd=%b n=%0d addr0=%h want 0/0/32/00040", to, fd, wa.size(), wa.size() ? wa[0] : '0);
    end
    pos = (pos + 1) % NB;
  endtask

`ifdef BLK_WR_CHECKSUM_EN
  task automatic test_checksum;
    mode = 1;
    run_block('0);
    checks++;
    if (to || checksum !== 16'h3FC0) begin errors++; $display("FAIL csum_ff: got %h want 3FC0", checksum); end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (checksum !== 16'h3FC0) begin errors++; $display("FAIL csum_hold: got %h want 3FC0", checksum); end
    pos = (pos + 1) % NB;
    mode = 0;
    run_block('0);
    checks++;
    if (to || checksum !== 16'h07E0) begin errors++; $display("FAIL csum_ramp: got %h want 07E0", checksum); end
    pos = (pos + 1) % NB;
  endtask
`endif

  task automatic test_reset_mid;
    bit hit = 0;
    logic [AW+16+10-1:0] got;
    mode = 2;
    ack_tie = 1;
    wa.delete();
    wd.delete();
    @(negedge clock);
    start = 1;
    base_addr = 18'h00500;
    @(negedge clock);
    start = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clock);
      #1;
      if (wa.size() == 10 && sram_we) begin hit = 1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL mid_reach_word10: got n=%0d want 10 with we", wa.size()); end
    #2 reset_n = 0;
    #1;
    got = {sram_addr, sram_wdata, rd_row, rd_col, sram_we, busy, done, frame_done};
    checks++;
    if (got !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h want 0", got); end
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (wa.size() != 10 || sram_we !== 1'b0) begin
      errors++; $display("FAIL mid_no_writes: got n=%0d we=%b want 10/0", wa.size(), sram_we);
    end
    @(negedge clock);
    reset_n = 1;
    pos = 0;
    run_block(18'h00100);
    checks++;
    if (to || wa.size() != 32) begin errors++; $display("FAIL mid_after_count: got to=%b n=%0d want 0/32", to, wa.size()); end
    else for (int w = 0; w < 32; w++) begin
      checks++;
      if (wa[w] !== exp_addr(0, 'h100, w) || wd[w] !== exp_data(w)) begin
        errors++; $display("FAIL mid_after_w%0d: got %h/%h want %h/%h", w, wa[w], wd[w], exp_addr(0, 'h100, w), exp_data(w));
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset_n = 1;
    test_reset();
    test_single_block();
    test_second_block();
    test_ack_delay();
    test_frame();
`ifdef BLK_WR_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
